// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/adder.sv
// Plain N-bit modulo adder; the carry out is dropped so pc arithmetic wraps.
module adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with redirect/kill handling
// and a one-entry delivery register held under downstream stall.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [N-1:0]       imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [N-1:0]       redirect_pc,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [N-1:0]       instr_pc
);

    fetch_state_e       state_q, state_d;
    logic [N-1:0]       pc_q, pc_d;
    logic               kill_q, kill_d;
    logic               pend_q, pend_d;
    logic [N-1:0]       pend_pc_q, pend_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [N-1:0]       instr_pc_q, instr_pc_d;
    logic [N-1:0]       pc_inc;
    logic [N-1:0]       tgt;

    assign tgt = redirect_pc & {{(N-2){1'b1}}, 2'b00};

    adder #(.N(N)) u_pc_inc (
        .a   (pc_q),
        .b   (N'(PC_INC)),
        .sum (pc_inc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_valid) pc_d = tgt;
            end
            FETCH: begin
                // The presented address must not move, so a redirect here is
                // parked and the in-flight response is killed once accepted.
                if (redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = tgt;
                end
                if (imem_ready) begin
                    state_d = WAIT;
                    kill_d  = pend_q | redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    kill_d    = 1'b1;
                    pend_d    = 1'b1;
                    pend_pc_d = tgt;
                end
                if (imem_rvalid) begin
                    if (kill_q || redirect_valid) begin
                        state_d = FETCH;
                        pc_d    = redirect_valid ? tgt : pend_pc_q;
                        kill_d  = 1'b0;
                        pend_d  = 1'b0;
                    end else begin
                        state_d    = DELIVER;
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                    end
                end
            end
            DELIVER: begin
                if (redirect_valid) begin
                    state_d = FETCH;
                    pc_d    = tgt;
                end else if (!stall) begin
                    state_d = FETCH;
                    pc_d    = pc_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == FETCH);
        imem_addr   = pc_q;
        instr_valid = (state_q == DELIVER);
        instr       = instr_q;
        instr_pc    = instr_pc_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed timing scenarios plus a randomized run checked
// against an architectural "next useful pc" model and a one-slot memory model.
module tb_fetch_ctrl;

    localparam int          N        = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_ctrl #(.N(N), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0093;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Model state: architectural next pc, outstanding memory slot, per-cycle log.
    logic [31:0] target;
    bit          os;
    logic [31:0] os_addr;
    bit          hold;
    logic [31:0] hold_addr;
    int          cyc;
    int          ndeliv = 0;
    logic        lv [64];
    logic        lr [64];
    logic [31:0] la [64];
    logic [31:0] lp [64];
    logic [31:0] li [64];

    always @(negedge clk) begin
        #3;
        if (!reset) begin
            chk("rst_req", {31'b0, imem_req}, 32'h0);
            chk("rst_addr", imem_addr, RESET_PC);
            chk("rst_vld", {31'b0, instr_valid}, 32'h0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_ipc", instr_pc, 32'h0);
            target = RESET_PC;
            os     = 1'b0;
            hold   = 1'b0;
            cyc    = 0;
        end else begin
            if (cyc < 64) begin
                lv[cyc] = instr_valid;
                lr[cyc] = imem_req;
                la[cyc] = imem_addr;
                lp[cyc] = instr_pc;
                li[cyc] = instr;
            end
            if (instr_valid) begin
                chk("deliver_pc", instr_pc, target);
                chk("deliver_instr", instr, mem(instr_pc));
                ndeliv++;
            end
            if (hold) begin
                chk("hold_req", {31'b0, imem_req}, 32'h1);
                chk("hold_addr", imem_addr, hold_addr);
            end
            if (imem_rvalid && os) os = 1'b0;
            if (imem_req) begin
                chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
                if (imem_ready) begin
                    chk("one_outstanding", {31'b0, os}, 32'h0);
                    os      = 1'b1;
                    os_addr = imem_addr;
                end
            end
            hold      = imem_req && !imem_ready;
            hold_addr = imem_addr;
            if (redirect_valid)
                target = redirect_pc & 32'hFFFF_FFFC;
            else if (instr_valid && !stall)
                target = target + 32'd4;
            cyc++;
        end
    end

    // rvm: 0 = no rvalid, 1 = answer the outstanding request, 2 = stray rvalid when idle
    task automatic tick(input bit rdy, input int rvm, input bit st, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        reset          = 1'b1;
        imem_ready     = rdy;
        imem_rvalid    = (rvm == 1) ? os : ((rvm == 2) ? !os : 1'b0);
        imem_rdata     = (rvm == 1 && os) ? mem(os_addr) : 32'hDEAD_BEEF;
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset          = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Back-to-back fetches at minimum latency
        do_reset(3);
        repeat (11) tick(1, 1, 0, 0, 0);
        #4;
        chk("a_vld3", {31'b0, lv[3]}, 1); chk("a_vld6", {31'b0, lv[6]}, 1);
        chk("a_vld9", {31'b0, lv[9]}, 1); chk("a_vld2", {31'b0, lv[2]}, 0);
        chk("a_vld5", {31'b0, lv[5]}, 0); chk("a_vld8", {31'b0, lv[8]}, 0);
        chk("a_addr1", la[1], 32'h0); chk("a_addr4", la[4], 32'h4); chk("a_addr7", la[7], 32'h8);

        // Five stall cycles in DELIVER
        do_reset(2);
        repeat (6) tick(1, 1, 0, 0, 0);
        repeat (5) tick(1, 1, 1, 0, 0);
        repeat (4) tick(1, 1, 0, 0, 0);
        #4;
        for (int c = 6; c <= 11; c++) begin
            chk("b_vld", {31'b0, lv[c]}, 1);
            chk("b_instr", li[c], 32'h0050_0093);
            chk("b_ipc", lp[c], 32'h4);
            chk("b_noreq", {31'b0, lr[c]}, 0);
        end
        chk("b_req12", {31'b0, lr[12]}, 1); chk("b_addr12", la[12], 32'h8);

        // Redirect in WAIT with rvalid in the same cycle
        do_reset(2);
        repeat (2) tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 1, 32'h100);
        repeat (4) tick(1, 1, 0, 0, 0);
        #4;
        chk("c_vld3", {31'b0, lv[3]}, 0); chk("c_req3", {31'b0, lr[3]}, 1);
        chk("c_addr3", la[3], 32'h100); chk("c_vld5", {31'b0, lv[5]}, 1);
        chk("c_ipc5", lp[5], 32'h100);

        // Redirect in FETCH while the memory stalls for three cycles
        do_reset(2);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 32'h200);
        repeat (2) tick(0, 1, 0, 0, 0);
        repeat (6) tick(1, 1, 0, 0, 0);
        #4;
        for (int c = 1; c <= 4; c++) begin
            chk("d_req", {31'b0, lr[c]}, 1);
            chk("d_addr", la[c], 32'h0);
        end
        for (int c = 5; c <= 7; c++) chk("d_novld", {31'b0, lv[c]}, 0);
        chk("d_addr6", la[6], 32'h200); chk("d_vld8", {31'b0, lv[8]}, 1);
        chk("d_ipc8", lp[8], 32'h200);

        // Redirect during IDLE to the top word, then wrap on consume
        do_reset(2);
        tick(1, 1, 0, 1, 32'hFFFF_FFFF);
        repeat (5) tick(1, 1, 0, 0, 0);
        #4;
        chk("e_addr1", la[1], 32'hFFFF_FFFC); chk("e_ipc3", lp[3], 32'hFFFF_FFFC);
        chk("e_req4", {31'b0, lr[4]}, 1); chk("e_addr4", la[4], 32'h0);

        // Reset while waiting; stray rvalid afterwards must be ignored
        do_reset(2);
        repeat (2) tick(1, 1, 0, 0, 0);
        do_reset(3);
        repeat (2) tick(0, 2, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        repeat (3) tick(1, 1, 0, 0, 0);
        #4;
        for (int c = 0; c <= 3; c++) chk("f_novld", {31'b0, lv[c]}, 0);
        chk("f_req1", {31'b0, lr[1]}, 1); chk("f_addr1", la[1], RESET_PC);
        chk("f_vld4", {31'b0, lv[4]}, 1); chk("f_ipc4", lp[4], RESET_PC);

        // Randomized traffic
        do_reset(2);
        ndeliv = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            int          rvm;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            rvm = ($urandom_range(0, 9) < 6) ? 1 : (($urandom_range(0, 29) == 0) ? 2 : 0);
            if ($urandom_range(0, 999) == 0)
                do_reset(2);
            else
                tick($urandom_range(0, 9) < 7, rvm, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 99) < 8, rpc);
        end
        #4;
        chk("progress", {31'b0, ndeliv > 100}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, PC/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  N  fetch address, word-aligned.
REQ-007 SHALL have port imem_ready  input  1  memory accepts request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid.
REQ-009 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  taken branch/jump, one-cycle pulse.
REQ-011 SHALL have port redirect_pc  input  N  branch/jump target.
REQ-012 SHALL have port stall  input  1  downstream cannot accept the instruction.
REQ-013 SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-014 SHALL have port instr  output  32  fetched instruction.
REQ-015 SHALL have port instr_pc  output  N  address of instr.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, DELIVER; at most one outstanding request.
REQ-017 IDLE SHALL last exactly one cycle after reset deassertion, then go to FETCH.
REQ-018 FETCH SHALL drive imem_req=1, imem_addr=pc; on imem_ready go to WAIT; imem_addr SHALL be stable while imem_req=1 and imem_ready=0.
REQ-019 WAIT SHALL capture imem_rdata into instr on imem_rvalid and go to DELIVER; imem_rvalid in any other state SHALL be ignored.
REQ-020 DELIVER SHALL hold instr_valid=1 with stable instr/instr_pc while stall=1.
REQ-021 On instr_valid=1 and stall=0, pc SHALL become pc+4 (mod 2^N; 0xFFFF_FFFC wraps to 0), FSM SHALL go to FETCH next cycle.
REQ-022 Minimum latency: request accepted in cycle t, rvalid in t+1 gives instr_valid in t+2.
REQ-023 Redirect in DELIVER SHALL clear instr_valid next cycle, set pc=redirect_pc, go to FETCH; simultaneous consume counts the current instruction as delivered and redirect wins over pc+4.
REQ-024 Redirect in WAIT SHALL set kill flag and pending target; the returning rvalid (even in the same cycle) SHALL be discarded, then FETCH from target.
REQ-025 Redirect in FETCH without imem_ready SHALL be held pending (address stays stable); after acceptance the response SHALL be killed as in REQ-024; redirect with imem_ready in the same cycle SHALL behave as REQ-024.
REQ-026 Multiple redirects before use: the latest redirect_pc SHALL win.
REQ-027 Redirect in IDLE SHALL replace RESET_PC as first fetch address.
REQ-028 redirect_pc bits [1:0] SHALL be forced to 0.

Reset
REQ-029 On reset=0, outputs SHALL be imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0; pc=RESET_PC; kill/pending cleared; state IDLE.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a later stray imem_rvalid SHALL not produce instr_valid.

Structure
REQ-031 fetch_pkg SHALL hold the state enum, INSTR_W=32, PC_INC=4.
REQ-032 pc+4 SHALL be produced by an instance of the existing adder #(N) module; no other sub-module.

Verification
REQ-033 Reset release, imem_ready=1, rvalid one cycle later, stall=0 -> addresses 0x0,0x4,0x8 fetched; instr_valid at cycles 3,6,9 after IDLE.
REQ-034 stall=1 for 5 cycles in DELIVER with instr 0x00500093 -> instr/instr_pc (0x4) stable, no imem_req, then next fetch at 0x8.
REQ-035 Redirect to 0x100 in WAIT with rvalid same cycle -> data discarded, next imem_addr 0x100, instr_pc 0x100.
REQ-036 Redirect to 0x200 in FETCH with imem_ready=0 for 3 cycles -> imem_addr stays old value until accepted, response killed, next fetch 0x200.
REQ-037 pc=0xFFFF_FFFC consumed -> next imem_addr 0x0000_0000.
REQ-038 reset asserted in WAIT, rvalid arrives during IDLE -> instr_valid stays 0, first fetch at RESET_PC.
